// File: rtl/store_merge_pkg.sv
// Shared opcode, FSM state and payload definitions for the byte/half/word store merger.
package store_merge_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [OP_W-1:0] OP_SB = 6'h28;
    localparam logic [OP_W-1:0] OP_SH = 6'h29;
    localparam logic [OP_W-1:0] OP_SW = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Byte enables plus lane-replicated store data
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } lane_t;

    // Enabled lanes take the store data, the rest keep the word read from memory
    function automatic logic [DATA_W-1:0] merge_word(input logic [BE_W-1:0]   be,
                                                     input logic [DATA_W-1:0] lane,
                                                     input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] w;
        w = rdata;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) w[8*i +: 8] = lane[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/store_lane.sv
// Combinational store decode: byte enables, lane replication and misalignment/illegal-op detection.
module store_lane
    import store_merge_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output lane_t             lane_c,
    output logic              bad_c
);

    always_comb begin
        lane_c = '0;
        bad_c  = 1'b0;
        case (op)
            OP_SB: begin
                lane_c.be   = BE_W'(4'b0001 << addr_lo);
                lane_c.data = {4{wdata[7:0]}};
            end
            OP_SH: begin
                lane_c.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_c.data = {2{wdata[15:0]}};
                bad_c       = addr_lo[0];
            end
            OP_SW: begin
                lane_c.be   = 4'b1111;
                lane_c.data = wdata;
                bad_c       = (addr_lo != 2'b00);
            end
            default: bad_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_merge.sv
// Sub-word store engine: read-modify-write for SB/SH, direct write for SW, with ack timeout.
module store_merge
    import store_merge_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [BE_W-1:0]   be,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   lane_q, lane_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                req_ready_d, mem_rd_d, mem_wr_d, done_d, err_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [BE_W-1:0]     be_d;
    lane_t               lane_c;
    logic                bad_c;

    store_lane u_lane (
        .op      (op),
        .addr_lo (addr[1:0]),
        .wdata   (wdata),
        .lane_c  (lane_c),
        .bad_c   (bad_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        wait_d      = wait_q;
        mem_rd_d    = mem_rd;
        mem_wr_d    = mem_wr;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        be_d        = be;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    be_d        = lane_c.be;
                    lane_d      = lane_c.data;
                    mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = lane_c.data;
                    if (bad_c) begin
                        err_d = 1'b1;
                    end else if (op == OP_SW) begin
                        state_d  = ST_WRITE;
                        mem_wr_d = 1'b1;
                        wait_d   = '0;
                    end else begin
                        state_d  = ST_READ;
                        mem_rd_d = 1'b1;
                        wait_d   = '0;
                    end
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = merge_word(be, lane_q, mem_rdata);
                    wait_d      = '0;
                    state_d     = ST_WRITE;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                    if (wait_q == CNT_LAST) begin
                        mem_rd_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    mem_wr_d = 1'b0;
                    state_d  = ST_FINISH;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                    if (wait_q == CNT_LAST) begin
                        mem_wr_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            wait_q    <= '0;
            req_ready <= 1'b1;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            be        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            wait_q    <= wait_d;
            req_ready <= req_ready_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            be        <= be_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_store_merge.sv
// Directed vector bench for store_merge: table of stores plus timeout and mid-write reset sequences.
module tb_store_merge;
    import store_merge_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [BE_W-1:0]   be;
    logic              done;
    logic              err;

    logic              ack_en;
    int                tests = 0;
    int                fails = 0;
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    int                overlap = 0;
    logic [DATA_W-1:0] wr_data_seen;
    logic [ADDR_W-1:0] wr_addr_seen;

    store_merge #(.ACK_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .be        (be),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Memory responds on the first request cycle when enabled
    assign mem_ack = ack_en & (mem_rd | mem_wr);

    always @(posedge clk) begin
        if (mem_rd && mem_wr) overlap++;
        if (mem_rd && mem_ack) rd_cnt++;
        if (mem_wr && mem_ack) begin
            wr_cnt++;
            wr_data_seen = mem_wdata;
            wr_addr_seen = mem_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              exp_err;
        logic [BE_W-1:0]   exp_be;
        logic [DATA_W-1:0] exp_wdata;
        int                exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int   got_k;
        logic got_err;
        logic rd1, wr1, rdy1;
        logic [BE_W-1:0]   be1;
        logic [ADDR_W-1:0] addr1;
        int   rd0, wr0;
        string tag;
        tag = $sformatf("v%0d", idx);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        got_k = 0;
        got_err = 1'b0;
        rd1 = 1'b0; wr1 = 1'b0; rdy1 = 1'b0; be1 = '0; addr1 = '0;
        @(negedge clk);
        req_valid = 1'b1;
        op        = v.op;
        addr      = v.addr;
        wdata     = v.wdata;
        mem_rdata = v.rdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20 && got_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd1 = mem_rd; wr1 = mem_wr; rdy1 = req_ready; be1 = be; addr1 = mem_addr;
            end
            if (done || err) begin
                got_k   = k;
                got_err = err;
            end
        end
        if (got_k == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done/err within 20 cycles", tag);
        end
        chk({tag, "_lat"}, 32'(got_k), 32'(v.exp_lat));
        chk({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
        chk({tag, "_ready_t1"}, 32'(rdy1), 32'(v.exp_err));
        chk({tag, "_rd_t1"}, 32'(rd1), 32'(!v.exp_err && v.op != OP_SW));
        chk({tag, "_wr_t1"}, 32'(wr1), 32'(!v.exp_err && v.op == OP_SW));
        if (v.exp_err) begin
            chk({tag, "_no_rd"}, 32'(rd_cnt - rd0), 32'd0);
            chk({tag, "_no_wr"}, 32'(wr_cnt - wr0), 32'd0);
        end else begin
            chk({tag, "_be"}, 32'(be1), 32'(v.exp_be));
            chk({tag, "_maddr"}, addr1, v.addr & 32'hFFFF_FFFC);
            chk({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'd1);
            chk({tag, "_wdata"}, wr_data_seen, v.exp_wdata);
            chk({tag, "_wr_addr"}, wr_addr_seen, v.addr & 32'hFFFF_FFFC);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          1'b0, 4'b1111, 32'hDEAD_BEEF, 3};
        vecs[1] = '{OP_SB,  32'h0000_0203, 32'h0000_00A5, 32'h1122_3344, 1'b0, 4'b1000, 32'hA522_3344, 4};
        vecs[2] = '{OP_SH,  32'h0000_0302, 32'h0000_CAFE, 32'h1122_3344, 1'b0, 4'b1100, 32'hCAFE_3344, 4};
        vecs[3] = '{OP_SH,  32'h0000_0301, 32'h0000_CAFE, 32'h1122_3344, 1'b1, 4'b0000, 32'h0,          1};
        vecs[4] = '{OP_SB,  32'h0000_0000, 32'h1234_5677, 32'hAABB_CCDD, 1'b0, 4'b0001, 32'hAABB_CC77, 4};
        vecs[5] = '{OP_SB,  32'h0000_0001, 32'h0000_00FF, 32'h0000_0000, 1'b0, 4'b0010, 32'h0000_FF00, 4};
        vecs[6] = '{OP_SH,  32'h0000_0000, 32'hFFFF_1234, 32'hAABB_CCDD, 1'b0, 4'b0011, 32'hAABB_1234, 4};
        vecs[7] = '{OP_SW,  32'h0000_0102, 32'h0101_0101, 32'h0,          1'b1, 4'b0000, 32'h0,          1};
        vecs[8] = '{6'h00,  32'h0000_0000, 32'h0101_0101, 32'h0,          1'b1, 4'b0000, 32'h0,          1};
        vecs[9] = '{OP_SW,  32'hFFFF_FFFC, 32'h0123_4567, 32'h0,          1'b0, 4'b1111, 32'h0123_4567, 3};

        rst_n = 1'b0; req_valid = 1'b0; op = '0; addr = '0; wdata = '0;
        mem_rdata = '0; ack_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_be", 32'(be), 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // SB with no ack: four request cycles, then drop and err
        ack_en = 1'b0;
        begin
            int wr0;
            wr0 = wr_cnt;
            @(negedge clk);
            req_valid = 1'b1; op = OP_SB; addr = 32'h0000_0010; wdata = 32'h55;
            @(posedge clk);
            #1 req_valid = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k < 5) begin
                    chk($sformatf("to_rd_k%0d", k), 32'(mem_rd), 32'd1);
                    chk($sformatf("to_err_k%0d", k), 32'(err), 32'd0);
                end else begin
                    chk("to_rd_drop", 32'(mem_rd), 32'd0);
                    chk("to_err", 32'(err), 32'd1);
                    chk("to_ready", 32'(req_ready), 32'd1);
                end
                chk($sformatf("to_wr_k%0d", k), 32'(mem_wr), 32'd0);
            end
            @(negedge clk);
            chk("to_err_pulse", 32'(err), 32'd0);
            chk("to_no_write", 32'(wr_cnt - wr0), 32'd0);
        end

        // Reset in WRITE aborts silently, then a normal SW completes
        @(negedge clk);
        req_valid = 1'b1; op = OP_SW; addr = 32'h0000_0040; wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rw_wr_before", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_wr_async", 32'(mem_wr), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rw_quiet_%0d", k), 32'({done, err, mem_wr, mem_rd}), 32'd0);
        end
        rst_n = 1'b1;
        ack_en = 1'b1;
        v = '{OP_SW, 32'h0000_0044, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D, 3};
        run_vec(v, 10);

        chk("no_rd_wr_overlap", 32'(overlap), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, the maximum number of cycles to wait for mem_ack per memory access.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  store request present.
REQ-006 req_ready  output  1  block idle and able to accept a request.
REQ-007 op  input  6  store opcode: SB, SH or SW, from the shared opcode defines.
REQ-008 addr  input  32  byte address of the store.
REQ-009 wdata  input  32  register data; the low byte, low half or full word is used, per op.
REQ-010 mem_addr  output  32  word address to memory: {addr[31:2],2'b00}.
REQ-011 mem_rd  output  1  word read request, held until mem_ack.
REQ-012 mem_wr  output  1  word write request, held until mem_ack.
REQ-013 mem_wdata  output  32  merged word to write.
REQ-014 mem_rdata  input  32  read data, valid when mem_ack=1 during a read.
REQ-015 mem_ack  input  1  memory completion strobe for the current mem_rd or mem_wr.
REQ-016 be  output  4  byte enables of the accepted store, held for the whole operation.
REQ-017 done  output  1  one-cycle pulse when the store completes successfully.
REQ-018 err  output  1  one-cycle pulse on misalignment, illegal op, or timeout.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, WRITE and FINISH; req_ready SHALL be 1 only in IDLE.
REQ-020 SHALL register op, addr, wdata and be when req_valid and req_ready are both 1 (the accept cycle, T).
REQ-021 SHALL compute be as follows:
- SB: 4'b0001 << addr[1:0].
- SH: addr[1] ? 4'b1100 : 4'b0011.
- SW: 4'b1111.
REQ-022 SHALL replicate lane data as follows: SB writes wdata[7:0] to all four bytes; SH writes wdata[15:0] to both halves; SW writes wdata unchanged.
REQ-023 SHALL flag these requests as errors: SH with addr[0]=1, SW with addr[1:0]!=0, or any op other than SB/SH/SW.
REQ-024 On an error request, SHALL pulse err at T+1, issue no memory access, and return to IDLE at T+1.
REQ-025 For a legal SW, SHALL go IDLE->WRITE, with mem_wr=1 and mem_wdata equal to the lane data from T+1.
REQ-026 For a legal SB or SH, SHALL go IDLE->READ, with mem_rd=1 from T+1.
REQ-027 On mem_ack in READ, SHALL capture the merged word: lane i comes from the lane data if be[i]=1, otherwise from mem_rdata lane i. The FSM SHALL then enter WRITE on the next cycle.
REQ-028 On mem_ack in WRITE, SHALL enter FINISH; in FINISH, SHALL pulse done for one cycle and return to IDLE.
REQ-029 SHALL never assert mem_rd and mem_wr together, and SHALL deassert each in the cycle after its mem_ack.
REQ-030 SHALL ignore mem_ack while in IDLE or FINISH.
REQ-031 SHALL keep a wait counter that resets on entry to READ or WRITE and increments each cycle without mem_ack.
REQ-032 When the wait counter reaches ACK_TIMEOUT, SHALL drop mem_rd/mem_wr, pulse err, and return to IDLE without writing.
REQ-033 Minimum latency, from accept to done pulse, with mem_ack at the first request cycle:
- SW: 3 cycles.
- SB/SH: 4 cycles.
REQ-034 SHALL hold mem_addr, mem_wdata and be stable while mem_rd or mem_wr is asserted.
REQ-035 SHALL ignore req_valid outside IDLE; no request queuing.

Reset
REQ-036 While rst_n=0, SHALL hold state at IDLE with req_ready=1 and the following outputs at 0: mem_rd, mem_wr, done, err, be, mem_addr, mem_wdata, and the wait counter.
REQ-037 A reset asserted mid-operation SHALL abort immediately with no done or err pulse; the memory request drops asynchronously.

Structure
REQ-038 Opcode constants SB/SH/SW SHALL come from the shared opcode define file, and FSM state encodings SHALL come from the shared defines file; neither is redefined locally.
REQ-039 The be/lane-replication/misalignment decode SHALL be one combinational sub-module, store_lane, instantiated once.
REQ-040 All sequential logic (FSM, registers, counter) SHALL reside in store_merge.

Verification
REQ-041 SW: addr=0x100, wdata=0xDEADBEEF, mem_ack on the first cycle -> no mem_rd; mem_wr at T+1 with mem_addr=0x100, mem_wdata=0xDEADBEEF, be=4'b1111; done at T+3.
REQ-042 SB: addr=0x203, wdata=0x000000A5, mem_rdata=0x11223344 -> be=4'b1000; mem_wdata=0xA5223344; done at T+4.
REQ-043 SH: addr=0x302, wdata=0x0000CAFE, mem_rdata=0x11223344 -> be=4'b1100; mem_wdata=0xCAFE3344.
REQ-044 SH: addr=0x301 -> err pulse at T+1; mem_rd and mem_wr stay 0; req_ready=1 at T+1.
REQ-045 SB with mem_ack never asserted, ACK_TIMEOUT=4 -> mem_rd drops and err pulses after 4 wait cycles; no mem_wr.
REQ-046 rst_n low during WRITE -> mem_wr=0 immediately; no done pulse; after release, an SW request completes normally.
